fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order word requests, instruction buffer, redirect squash.
// Optional FETCH_HALT_EN adds a halt input and a halted status output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_HALT_EN
  input  logic        halt,
  output logic        halted,
`endif
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc
);

  // Handshakes: a transfer happens on a cycle where valid && ready at the rising
  // edge; valid never depends on ready of the same channel except for the request
  // credit, which counts a same-cycle decode pop as a freed buffer slot.

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {RESET_WAIT, RUN} state_t;

  state_t      state, state_next;
  logic [29:0] pc;
  logic [29:0] rsp_pc;
  logic [CW-1:0] inflight, inflight_next;
  logic [CW-1:0] count;
  logic [CW-1:0] discard;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] pc_q   [FIFO_DEPTH];

  logic        halt_w;
  logic        req_fire;
  logic        pop;
  logic        push;
  logic [CW:0] occupancy;
  logic [1:0]  unused_redirect_bits;

`ifdef FETCH_HALT_EN
  assign halt_w = halt;
`else
  assign halt_w = 1'b0;
`endif

  assign unused_redirect_bits = redirect_pc[1:0];

  always_comb begin
    state_next = state;
    case (state)
      RESET_WAIT: state_next = RUN;
      RUN:        state_next = RUN;
      default:    state_next = RESET_WAIT;
    endcase
  end

  assign ir_valid  = (count != '0);
  assign ir        = data_q[rd_ptr];
  assign ir_pc     = pc_q[rd_ptr];
  assign pop       = ir_valid && ir_ready && !redirect_valid;
  // A redirect drops the same-cycle response as well as every later stale one.
  assign push      = imem_rsp_valid && (discard == '0) && !redirect_valid;

  // Outstanding requests plus buffered words never exceed the buffer size,
  // so every response is guaranteed a slot.
  assign occupancy = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = (state == RUN) && !redirect_valid && !halt_w &&
                          (occupancy < DEPTH_W);
  assign imem_addr = {pc, 2'b00};
  assign req_fire  = imem_req_valid && imem_req_ready;

  assign inflight_next = inflight + {{(CW-1){1'b0}}, req_fire}
                                  - {{(CW-1){1'b0}}, imem_rsp_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_WAIT;
      pc       <= RESET_PC[31:2];
      rsp_pc   <= RESET_PC[31:2];
      inflight <= '0;
      count    <= '0;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= NOP;
        pc_q[i]   <= '0;
      end
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
      if (redirect_valid) begin
        pc      <= redirect_pc[31:2];
        rsp_pc  <= redirect_pc[31:2];
        discard <= inflight_next;
        count   <= '0;
        rd_ptr  <= wr_ptr;
      end else begin
        if (req_fire) pc <= pc + 30'd1;
        if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          data_q[wr_ptr] <= imem_rsp_data;
          pc_q[wr_ptr]   <= {rsp_pc, 2'b00};
          wr_ptr         <= wr_ptr + PW'(1);
          rsp_pc         <= rsp_pc + 30'd1;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted <= 1'b0;
    else        halted <= halt && (inflight_next == '0);
  end
`endif

  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a redirect-alignment table and a
// randomized run against a request/delivery scoreboard with a latency-modelled memory.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
`ifdef FETCH_HALT_EN
  logic        halt = 1'b0;
  logic        halted;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_HALT_EN
    .halt(halt), .halted(halted),
`endif
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc)
  );

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] target; logic [31:0] exp0; logic [31:0] exp1;} vec_t;

  int checks = 0;
  int failures = 0;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] model_req_pc;
  int cyc, last_due, lat_min, lat_max, rdy_pct, fires;
  bit exp_ir_invalid, hold_chk;
  logic [31:0] prev_ir, prev_ir_pc;
  logic s_req_valid, s_req_fire, s_ir_valid;
  logic [31:0] s_ir_pc;
  vec_t vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; ir_ready = 1'b0;
    mem_q.delete(); exp_q.delete(); got_q.delete();
    exp_ir_invalid = 0; hold_chk = 0;
    @(posedge clk); #1;
    check("reset_req_valid", imem_req_valid, 1'b0);
    check("reset_ir_valid", ir_valid, 1'b0);
    check("reset_ir", ir, NOP);
    check("reset_ir_pc", ir_pc, 32'h0);
    rst_n = 1'b1;
    model_req_pc = 32'h0; cyc = 0; last_due = 0; fires = 0;
  endtask

  // One clock cycle; entered and left 1 time unit after the rising edge.
  task automatic step();
    bit rsp_fire;
    bit pop;
    int lat, due;
    rsp_fire = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp_fire;
    imem_rsp_data  = rsp_fire ? mem_word(mem_q[0].addr) : $urandom;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    #1;
    s_req_valid = imem_req_valid;
    s_req_fire  = imem_req_valid && imem_req_ready;
    s_ir_valid  = ir_valid;
    s_ir_pc     = ir_pc;
    if (exp_ir_invalid) check("ir_valid_after_redirect", ir_valid, 1'b0);
    if (hold_chk) begin
      check("hold_valid", ir_valid, 1'b1);
      check("hold_ir", ir, prev_ir);
      check("hold_ir_pc", ir_pc, prev_ir_pc);
    end
    if (redirect_valid) check("no_req_on_redirect", imem_req_valid, 1'b0);
`ifdef FETCH_HALT_EN
    if (halt) check("no_req_while_halt", imem_req_valid, 1'b0);
    if (halted) check("halted_idle", mem_q.size() == 0, 1'b1);
`endif
    if (s_req_fire) check("req_addr", imem_addr, model_req_pc);
    pop = ir_valid && ir_ready && !redirect_valid;
    if (pop) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_ir actual_pc=%h required=none", ir_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("ir_pc", ir_pc, e);
        check("ir_word", ir, mem_word(e));
      end
      got_q.push_back(ir_pc);
    end
    hold_chk = ir_valid && !ir_ready && !redirect_valid;
    prev_ir = ir; prev_ir_pc = ir_pc;
    if (s_req_fire) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: model_req_pc, due: due});
      exp_q.push_back(model_req_pc);
      model_req_pc = model_req_pc + 32'd4;
      fires++;
    end
    if (rsp_fire) void'(mem_q.pop_front());
    exp_ir_invalid = redirect_valid;
    if (redirect_valid) begin
      exp_q.delete();
      model_req_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    got_q.delete();
    redirect_valid = 1'b1; redirect_pc = t;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int first_req, first_val;
    bit found;
    vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_0006, 32'h0000_0004, 32'h0000_0008};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
    lat_min = 1; lat_max = 1; rdy_pct = 100;

    // Sequential fetch, first-word latency, throughput.
    do_reset();
    ir_ready = 1'b1;
    step();
    check("reset_wait_no_req", s_req_valid, 1'b0);
    first_req = -1; first_val = -1;
    for (int i = 0; i < 11; i++) begin
      step();
      if (s_req_fire && first_req < 0) first_req = cyc - 1;
      if (s_ir_valid && first_val < 0) first_val = cyc - 1;
    end
    check("t1_latency", first_val - first_req, 2);
    check("t1_throughput", got_q.size(), 9);
    if (got_q.size() >= 3) begin
      check("t1_pc0", got_q[0], 32'h0);
      check("t1_pc1", got_q[1], 32'h4);
      check("t1_pc2", got_q[2], 32'h8);
    end

    // Decode stall then release.
    do_reset();
    ir_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t2_fires", fires, DEPTH);
    check("t2_req_dropped", s_req_valid, 1'b0);
    check("t2_ir_valid", s_ir_valid, 1'b1);
    check("t2_ir_pc", s_ir_pc, 32'h0);
    ir_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t2_count", got_q.size() >= 3, 1'b1);
    if (got_q.size() >= 3) begin
      check("t2_pc0", got_q[0], 32'h0);
      check("t2_pc1", got_q[1], 32'h4);
      check("t2_pc2", got_q[2], 32'h8);
    end

    // Redirect with two slow responses in flight.
    do_reset();
    lat_min = 3; lat_max = 3; ir_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = (mem_q.size() == 2);
    end
    check("t3_two_inflight", found, 1'b1);
    redirect_to(32'h0000_0100);
    for (int i = 0; i < 15; i++) step();
    check("t3_delivered", got_q.size() > 0, 1'b1);
    if (got_q.size() > 0) check("t3_first_pc", got_q[0], 32'h0000_0100);

    // Redirect coinciding with a decode pop and a response arrival.
    do_reset();
    lat_min = 1; lat_max = 1; ir_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (i >= 4 && ir_valid && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1;
      else step();
    end
    check("t4_collision_found", found, 1'b1);
    redirect_to(32'h0000_0200);
    for (int i = 0; i < 10; i++) step();
    if (got_q.size() > 0) check("t4_first_pc", got_q[0], 32'h0000_0200);
    else check("t4_delivered", 1'b0, 1'b1);

    // Redirect target alignment and address wrap.
    lat_min = 2; lat_max = 2;
    for (int v = 0; v < 5; v++) begin
      redirect_to(vecs[v].target);
      for (int i = 0; i < 30 && got_q.size() < 2; i++) step();
      check("tab_count", got_q.size() >= 2, 1'b1);
      if (got_q.size() >= 2) begin
        check("tab_pc0", got_q[0], vecs[v].exp0);
        check("tab_pc1", got_q[1], vecs[v].exp1);
      end
    end

`ifdef FETCH_HALT_EN
    // Halt with two requests in flight, then resume sequentially.
    do_reset();
    lat_min = 3; lat_max = 3; ir_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = (mem_q.size() == 2);
    end
    halt = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = halted;
    end
    check("halt_reached", found, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check("halt_delivered", got_q.size(), 2);
    check("halt_still", halted, 1'b1);
    halt = 1'b0;
    for (int i = 0; i < 12; i++) step();
    if (got_q.size() >= 3) check("halt_resume_pc", got_q[2], 32'h8);
    else check("halt_resume_count", got_q.size() >= 3, 1'b1);
`endif

    // Randomized traffic: stalls, variable latency, redirects.
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      lat_min = 1; lat_max = 1 + seg; rdy_pct = 50 + 15 * seg;
      for (int i = 0; i < 300; i++) begin
        ir_ready = ($urandom_range(99) < 70);
        redirect_valid = ($urandom_range(99) < 4);
        redirect_pc = $urandom;
`ifdef FETCH_HALT_EN
        halt = ($urandom_range(99) < 10);
`endif
        step();
      end
      redirect_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
